// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: turns M-stage load/store controls into one
// req/ack data-SRAM transaction, stalling the pipeline until it completes.
// Optional macro ADDR_EXC_EN: misaligned accesses raise adelM/adesM instead
// of being silently force-aligned.
module mem_access_unit #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            memenM,
  input  logic            memwriteM,
  input  logic [1:0]      memsizeM,
  input  logic            memsignedM,
  input  logic [AW-1:0]   aluoutM,
  input  logic [DW-1:0]   writedataM,
  output logic [DW-1:0]   readdataM,
  output logic            stallM,
  output logic            data_req,
  output logic            data_wr,
  output logic [AW-1:0]   data_addr,
  output logic [DW/8-1:0] data_wstrb,
  output logic [DW-1:0]   data_wdata,
  input  logic            data_addr_ok,
  input  logic [DW-1:0]   data_rdata,
  input  logic            data_data_ok,
  output logic            adelM,
  output logic            adesM
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  off_q;

  logic        is_half;
  logic        is_word;
  logic        addr_exc;
  logic        start;
  logic [1:0]  eff_off;
  logic [3:0]  strobe;
  logic [31:0] wdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;

  // Reserved size 11 behaves exactly like a word access.
  assign is_word = memsizeM[1];
  assign is_half = (memsizeM == 2'b01);

`ifdef ADDR_EXC_EN
  logic misaligned;
  assign misaligned = (is_half && aluoutM[0]) || (is_word && (aluoutM[1:0] != 2'b00));
  assign addr_exc   = memenM && misaligned;
  assign eff_off    = aluoutM[1:0];
  assign adelM      = (state == IDLE) && addr_exc && !memwriteM;
  assign adesM      = (state == IDLE) && addr_exc && memwriteM;
`else
  assign addr_exc = 1'b0;
  assign eff_off  = is_word ? 2'b00 : (is_half ? {aluoutM[1], 1'b0} : aluoutM[1:0]);
  assign adelM    = 1'b0;
  assign adesM    = 1'b0;
`endif

  assign start  = (state == IDLE) && memenM && !addr_exc;
  assign stallM = start || (state == REQ) || (state == WAIT);

  always_comb begin
    strobe = 4'b1111;
    wdata  = writedataM;
    if (memsizeM == 2'b00) begin
      strobe = 4'b0001 << eff_off;
      wdata  = {4{writedataM[7:0]}};
    end else if (is_half) begin
      strobe = eff_off[1] ? 4'b1100 : 4'b0011;
      wdata  = {2{writedataM[15:0]}};
    end
    if (!memwriteM) strobe = 4'b0000;
  end

  // Load extraction uses the offset/size captured at request time, since the
  // M-stage inputs are not trusted while the access is outstanding.
  assign byte_sel = data_rdata[{off_q, 3'b000} +: 8];
  assign half_sel = off_q[1] ? data_rdata[31:16] : data_rdata[15:0];

  always_comb begin
    case (size_q)
      2'b00:   load_val = {{24{signed_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{signed_q & half_sel[15]}}, half_sel};
      default: load_val = data_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      readdataM  <= '0;
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_addr  <= '0;
      data_wstrb <= '0;
      data_wdata <= '0;
      size_q     <= 2'b00;
      signed_q   <= 1'b0;
      off_q      <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= REQ;
            data_req   <= 1'b1;
            data_wr    <= memwriteM;
            data_addr  <= {aluoutM[AW-1:2], 2'b00};
            data_wstrb <= strobe;
            data_wdata <= wdata;
            size_q     <= memsizeM;
            signed_q   <= memsignedM;
            off_q      <= eff_off;
          end
        end
        REQ: begin
          if (data_addr_ok) begin
            data_req <= 1'b0;
            if (data_data_ok) begin
              state <= DONE;
              if (!data_wr) readdataM <= load_val;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (data_data_ok) begin
            state <= DONE;
            if (!data_wr) readdataM <= load_val;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed and randomized accesses
// against a byte-lane reference model of the load/store rules.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        memenM, memwriteM, memsignedM;
  logic [1:0]  memsizeM;
  logic [31:0] aluoutM, writedataM;
  logic [31:0] readdataM;
  logic        stallM;
  logic        data_req, data_wr;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic        adelM, adesM;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rd = 32'h0;

  mem_access_unit #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .memenM(memenM), .memwriteM(memwriteM), .memsizeM(memsizeM),
    .memsignedM(memsignedM), .aluoutM(aluoutM), .writedataM(writedataM),
    .readdataM(readdataM), .stallM(stallM),
    .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_rdata(data_rdata),
    .data_data_ok(data_data_ok), .adelM(adelM), .adesM(adesM)
  );

  always #5 clk = ~clk;

  // Reference: bytes touched are nbytes lanes starting at the naturally
  // aligned offset; store data lane i carries store byte (i mod nbytes).
  task automatic model(input bit wr, input logic [1:0] sz, input bit sg,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, output logic [3:0] strb,
                       output logic [31:0] wdat, output logic [31:0] ld);
    int nb, off;
    logic [31:0] v;
    nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    off = (int'(addr[1:0]) / nb) * nb;
    strb = 4'b0000;
    for (int i = 0; i < nb; i++) if (wr) strb[off + i] = 1'b1;
    for (int i = 0; i < 4; i++) wdat[8*i +: 8] = wd[8*(i % nb) +: 8];
    v = rd >> (8 * off);
    if (nb == 1) begin
      v = v & 32'hFF;
      if (sg && v[7]) v = v | 32'hFFFFFF00;
    end else if (nb == 2) begin
      v = v & 32'hFFFF;
      if (sg && v[15]) v = v | 32'hFFFF0000;
    end
    ld = v;
  endtask

  task automatic do_access(input string name, input bit wr, input logic [1:0] sz,
                           input bit sg, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input int adly, input int ddly);
    logic [3:0]  strb;
    logic [31:0] wdat, ld;
    logic [69:0] bus_exp;
    model(wr, sz, sg, addr, wd, rd, strb, wdat, ld);
    bus_exp = {1'b1, wr, addr & 32'hFFFFFFFC, strb, wdat};
    @(negedge clk);
    memenM = 1'b1; memwriteM = wr; memsizeM = sz; memsignedM = sg;
    aluoutM = addr; writedataM = wd; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    data_rdata = $urandom;
    #1;
    checks++;
    if ({stallM, data_req, adelM, adesM} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL %s idle stall/req/adel/ades actual=%b expected=1000", name,
               {stallM, data_req, adelM, adesM});
    end
    for (int k = 0; k <= adly; k++) begin
      @(negedge clk);
      memenM = $urandom; memwriteM = $urandom; memsizeM = $urandom;
      aluoutM = $urandom; writedataM = $urandom; data_rdata = $urandom;
      data_addr_ok = (k == adly);
      data_data_ok = (k == adly) && (ddly == 0);
      if (data_data_ok) data_rdata = rd;
      #1;
      checks++;
      if ({data_req, data_wr, data_addr, data_wstrb, data_wdata} !== bus_exp || stallM !== 1'b1) begin
        errors++;
        $display("[TB] FAIL %s req bus actual=%h stall=%b expected=%h stall=1", name,
                 {data_req, data_wr, data_addr, data_wstrb, data_wdata}, stallM, bus_exp);
      end
    end
    for (int j = 1; j <= ddly; j++) begin
      @(negedge clk);
      memenM = $urandom; aluoutM = $urandom;
      data_addr_ok = 1'b0;
      data_data_ok = (j == ddly);
      data_rdata = data_data_ok ? rd : $urandom;
      #1;
      checks++;
      if (data_req !== 1'b0 || stallM !== 1'b1) begin
        errors++;
        $display("[TB] FAIL %s wait req/stall actual=%b%b expected=01", name, data_req, stallM);
      end
    end
    if (!wr) exp_rd = ld;
    @(negedge clk);
    memenM = $urandom; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
    #1;
    checks++;
    if (stallM !== 1'b0 || data_req !== 1'b0 || readdataM !== exp_rd) begin
      errors++;
      $display("[TB] FAIL %s done stall=%b req=%b readdataM actual=%h expected=%h", name,
               stallM, data_req, readdataM, exp_rd);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; memenM = 1'b0; memwriteM = 1'b0; memsizeM = 2'b00; memsignedM = 1'b0;
    aluoutM = '0; writedataM = '0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({readdataM, stallM, data_req, data_wr, data_addr, data_wstrb, data_wdata, adelM, adesM} !== '0) begin
      errors++;
      $display("[TB] FAIL reset outputs actual=%h/%b/%b/%b/%h/%b/%h/%b/%b expected=all zero",
               readdataM, stallM, data_req, data_wr, data_addr, data_wstrb, data_wdata, adelM, adesM);
    end
    exp_rd = 32'h0;
  endtask

  task automatic test_directed;
    do_access("lw_zero_wait", 1'b0, 2'b10, 1'b0, 32'h00000010, 32'h0, 32'h12345678, 0, 0);
    do_access("lb_signed", 1'b0, 2'b00, 1'b1, 32'h00000013, 32'h0, 32'h80AABBCC, 0, 0);
    do_access("lbu", 1'b0, 2'b00, 1'b0, 32'h00000013, 32'h0, 32'h80AABBCC, 0, 0);
    do_access("sh_0x22", 1'b1, 2'b01, 1'b0, 32'h00000022, 32'h0000BEEF, 32'hDEADDEAD, 0, 0);
    do_access("lh_signed_hi", 1'b0, 2'b01, 1'b1, 32'h00000102, 32'h0, 32'h9ABC1234, 1, 1);
    do_access("lw_delayed", 1'b0, 2'b10, 1'b0, 32'h00000040, 32'h0, 32'hCAFEF00D, 3, 2);
    do_access("sb_lane2", 1'b1, 2'b00, 1'b0, 32'h00000202, 32'h000000A5, 32'h0, 2, 0);
    do_access("sw_reserved_size", 1'b1, 2'b11, 1'b0, 32'h00000300, 32'h11223344, 32'h0, 0, 1);
  endtask

  task automatic test_idle_quiet;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      memenM = 1'b0; memwriteM = $urandom; memsizeM = $urandom;
      aluoutM = $urandom; writedataM = $urandom;
      #1;
      checks++;
      if (stallM !== 1'b0 || data_req !== 1'b0 || readdataM !== exp_rd) begin
        errors++;
        $display("[TB] FAIL idle_quiet stall=%b req=%b rd=%h expected 0/0/%h",
                 stallM, data_req, readdataM, exp_rd);
      end
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    memenM = 1'b1; memwriteM = 1'b0; memsizeM = 2'b10; aluoutM = 32'h80; data_addr_ok = 1'b0;
    @(negedge clk);
    memenM = 1'b0; data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0; rst = 1'b1;
    #1;
    checks++;
    if (stallM !== 1'b1 || data_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid wait stall/req actual=%b%b expected=10", stallM, data_req);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_rd = 32'h0;
    #1;
    checks++;
    if (stallM !== 1'b0 || data_req !== 1'b0 || readdataM !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid after stall=%b req=%b rd=%h expected 0/0/00000000",
               stallM, data_req, readdataM);
    end
  endtask

  task automatic test_misaligned;
`ifdef ADDR_EXC_EN
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      memenM = 1'b1; memwriteM = w[0]; memsizeM = 2'b10; aluoutM = 32'h00000002;
      #1;
      checks++;
      if ({adelM, adesM, stallM, data_req} !== {~w[0], w[0], 2'b00}) begin
        errors++;
        $display("[TB] FAIL misaligned exc adel/ades/stall/req actual=%b expected=%b",
                 {adelM, adesM, stallM, data_req}, {~w[0], w[0], 2'b00});
      end
      @(negedge clk);
      memenM = 1'b0;
      #1;
      checks++;
      if (data_req !== 1'b0 || stallM !== 1'b0 || adelM !== 1'b0 || readdataM !== exp_rd) begin
        errors++;
        $display("[TB] FAIL misaligned after req=%b stall=%b adel=%b rd=%h expected 0/0/0/%h",
                 data_req, stallM, adelM, readdataM, exp_rd);
      end
    end
`else
    do_access("lw_misaligned", 1'b0, 2'b10, 1'b0, 32'h00000002, 32'h0, 32'h76543210, 0, 0);
    do_access("lh_misaligned", 1'b0, 2'b01, 1'b1, 32'h00000007, 32'h0, 32'hF00D8001, 1, 0);
    do_access("sh_misaligned", 1'b1, 2'b01, 1'b0, 32'h00000011, 32'h00001234, 32'h0, 0, 2);
`endif
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = $urandom_range(0, 3);
      a  = $urandom;
`ifdef ADDR_EXC_EN
      if (sz == 2'b01) a[0] = 1'b0;
      if (sz[1]) a[1:0] = 2'b00;
`endif
      do_access("random", 1'($urandom), sz, 1'($urandom), a, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  task automatic test_back_to_back;
    do_access("b2b_sw", 1'b1, 2'b10, 1'b0, 32'h00000500, 32'hA1B2C3D4, 32'h0, 0, 0);
    do_access("b2b_lb", 1'b0, 2'b00, 1'b1, 32'h00000501, 32'h0, 32'h00007F00, 0, 0);
    do_access("b2b_lhu", 1'b0, 2'b01, 1'b0, 32'h00000502, 32'h0, 32'hFFFE0000, 0, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_idle_quiet();
    test_reset_mid();
    test_misaligned();
    test_random();
    test_back_to_back();
    @(negedge clk);
    memenM = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-stage load/store unit sitting directly downstream of the datapath's M-stage outputs. It takes the M-stage address and store data plus memory-op controls and issues a request/acknowledge transaction on the data-SRAM bus. It holds the pipeline through variable-latency responses, then returns the aligned, extended load word on readdataM for the W-stage register.

Parameters:
AW, 32, address width (only 32 supported; lower 2 bits are the byte offset)
DW, 32, data width (only 32 supported; 4 byte lanes)

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous active-high reset
memenM  in  1  M-stage instruction is a load or store
memwriteM  in  1  1=store, 0=load
memsizeM  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
memsignedM  in  1  loads: 1 sign-extend (LB/LH), 0 zero-extend (LBU/LHU)
aluoutM  in  32  effective byte address
writedataM  in  32  raw rt value for stores
readdataM  out  32  aligned/extended load result
stallM  out  1  freeze F/D/E/M while access is outstanding
data_req  out  1  bus request valid
data_wr  out  1  1=write
data_addr  out  32  word address {addr[31:2],2'b00}
data_wstrb  out  4  byte write enables (0000 for reads)
data_wdata  out  32  lane-replicated store data
data_addr_ok  in  1  slave accepted request this cycle
data_rdata  in  32  read data, valid with data_data_ok
data_data_ok  in  1  transaction complete
adelM  out  1  load address error (feature-gated)
adesM  out  1  store address error (feature-gated)

Behaviour:
- Reset: state IDLE; readdataM=0; stallM=0; data_req=0, data_wr=0, data_addr=0, data_wstrb=0, data_wdata=0; adelM=adesM=0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: if memenM and not address-error, capture addr/size/signed/write/strobe/wdata into registers, go to REQ; stallM=1 combinationally this cycle. Otherwise stay; stallM=0.
- REQ: data_req=1. All bus fields are held stable until data_addr_ok. On addr_ok&&data_ok same cycle go to DONE, on addr_ok only go to WAIT. stallM=1.
- WAIT: data_req=0; on data_data_ok go to DONE. stallM=1.
- Read completion (REQ or WAIT with data_ok): register the extracted load result into readdataM.
- DONE: stallM=0 for exactly one cycle; readdataM is valid for W-stage capture at the end of this cycle; next state IDLE.
- Minimum occupancy for a zero-wait slave: 3 cycles (IDLE, REQ, DONE).
- Stores never modify readdataM.
- Load extract: off=addr[1:0]. Byte uses rdata[8*off+7:8*off]. Half uses rdata[31:16] if off[1] else rdata[15:0]. Extend per memsignedM; word is passed through.
- Store lanes: byte wstrb=0001<<off, wdata={4{wd[7:0]}}. Half wstrb=0011<<off (off[1] only), wdata={2{wd[15:0]}}. Word wstrb=1111, wdata=wd.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
- memenM is sampled only in IDLE. Changes while busy are ignored; the pipeline is frozen in that period.
- Reset mid-transaction returns to IDLE and drops data_req. The bus slave shares rst, so no stale data_ok is expected.
- An IDLE-to-IDLE cycle with memenM=0 produces no bus activity.

Optional Feature:
ADDR_EXC_EN.
- Defined: a misaligned access in IDLE issues no bus request and keeps stallM=0. It asserts adelM (load) or adesM (store) combinationally for that cycle, and readdataM is unchanged.
- Undefined: adelM=adesM=0 constant. Misaligned accesses proceed with the offset forced to natural alignment (half clears addr[0]; word clears addr[1:0]).

Test Plan:
- LW 0x00000010 with a zero-wait slave (addr_ok and data_ok in the REQ cycle) returning 0x12345678 -> data_addr=0x10, wstrb=0000, stallM high 2 cycles, readdataM=0x12345678 in DONE.
- LB signed at 0x13 with rdata 0x80AABBCC -> readdataM=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH at 0x22 with writedataM=0x0000BEEF -> data_addr=0x20, wstrb=1100, wdata=0xBEEFBEEF, data_wr=1, readdataM unchanged.
- LW with addr_ok delayed 3 cycles and data_ok 2 cycles after that -> data_req and bus fields stable through REQ, stallM continuous, single DONE cycle.
- rst asserted in WAIT -> next cycle state IDLE, stallM=0, data_req=0, readdataM=0.
- LW at 0x02:
  - ADDR_EXC_EN defined -> adelM=1 for one cycle, no data_req, stallM=0.
  - ADDR_EXC_EN undefined -> access to 0x00 completes normally.
